// File: rtl/sccb_write.sv
// sccb_write: SCCB 3-phase write master (DEV_ID, sub-address, data); optional NACK check via `define SCCB_ACK_CHECK_EN
//   params : CLK_FREQ (Hz), SCCB_FREQ (Hz), DEV_ID (write ID sent first)
//   inputs : clk, rst (sync, active-high), start (pulse, accepted in IDLE), addr[7:0], data[7:0], siod_in (SIO_D readback)
//   outputs: sioc, siod_out, siod_oe (1 = drive), busy, done (1-cycle pulse), ack_err (sticky NACK, 0 unless SCCB_ACK_CHECK_EN)
module sccb_write #(
  parameter int CLK_FREQ = 25000000,
  parameter int SCCB_FREQ = 100000,
  parameter logic [7:0] DEV_ID = 8'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       siod_in,
  output logic       sioc,
  output logic       siod_out,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);
  localparam int QRAW = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QTR = QRAW < 1 ? 1 : QRAW;
  localparam logic [15:0] QM = 16'(QTR - 1);
  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [1:0] q;
  logic [3:0] bitn;
  logic [1:0] byten;
  logic [23:0] sh;
  logic tick;
  assign tick = cnt == QM;
`ifndef SCCB_ACK_CHECK_EN
  logic unused;
  assign unused = siod_in;
`endif
  // Outputs are loaded at the edge that opens each quarter, so they hold for the whole quarter.
  // sh[23] is always the MSB of the byte in flight; it shifts once per data bit, not on the 9th bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      bitn <= '0;
      byten <= '0;
      sh <= '0;
      sioc <= 1'b1;
      siod_out <= 1'b1;
      siod_oe <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) cnt <= tick ? '0 : cnt + 16'd1;
`ifdef SCCB_ACK_CHECK_EN
      if (state == BIT && bitn == 4'd8 && q == 2'd2 && cnt == '0 && siod_in) ack_err <= 1'b1;
`endif
      case (state)
        IDLE: if (start) begin
          sh <= {DEV_ID, addr, data};
          ack_err <= 1'b0;
          bitn <= '0;
          byten <= '0;
          q <= '0;
          cnt <= '0;
          busy <= 1'b1;
          sioc <= 1'b1;
          siod_out <= 1'b1;
          siod_oe <= 1'b1;
          state <= START;
        end
        START: if (tick) begin
          if (q == 2'd0) begin
            q <= 2'd1;
            siod_out <= 1'b0;
          end else begin
            q <= 2'd0;
            sioc <= 1'b0;
            siod_out <= sh[23];
            state <= BIT;
          end
        end
        BIT: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd1) sioc <= 1'b1;
          else if (q == 2'd3) begin
            sioc <= 1'b0;
            if (bitn == 4'd8) begin
              siod_oe <= 1'b1;
              bitn <= '0;
              if (byten == 2'd2) begin
                siod_out <= 1'b0;
                state <= STOP;
              end else begin
                byten <= byten + 2'd1;
                siod_out <= sh[23];
              end
            end else begin
              sh <= sh << 1;
              bitn <= bitn + 4'd1;
              if (bitn == 4'd7) siod_oe <= 1'b0;
              else siod_out <= sh[22];
            end
          end
        end
        STOP: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd0) sioc <= 1'b1;
          else if (q == 2'd1) siod_out <= 1'b1;
          else if (q == 2'd3) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_write.sv
// tb_sccb_write: directed self-checking bench for sccb_write at QTR=2
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end
module tb_sccb_write;
  logic clk = 1'b0;
  logic rst, start, siod_in;
  logic [7:0] addr, data;
  logic sioc, siod_out, siod_oe, busy, done, ack_err;
  int checks = 0;
  int errors = 0;
  logic [23:0] rx;
  int nrise, lat, sf, sr, sf_cyc, sr_cyc, bad, nbusy_low, oe_bad, ndone;
  logic ack_mid, ack_done, ack_c1;
  sccb_write #(.CLK_FREQ(800), .SCCB_FREQ(100), .DEV_ID(8'h42)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data), .siod_in(siod_in),
    .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy), .done(done), .ack_err(ack_err)
  );
  always #5 clk = ~clk;
  // Follows one transaction from the cycle after start is sampled until done (or a 400-cycle budget).
  task automatic watch(input int coll_at, input bit b2b, input bit ack2);
    logic ps, pd;
    rx = '0; nrise = 0; lat = -1; sf = 0; sr = 0; sf_cyc = 0; sr_cyc = 0;
    bad = 0; nbusy_low = 0; oe_bad = 0; ack_mid = 1'bx; ack_done = 1'bx; ack_c1 = 1'bx;
    ps = sioc; pd = siod_out;
    for (int cyc = 1; cyc <= 400 && lat < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) ack_c1 = ack_err;
      if (cyc == coll_at) begin start = 1'b1; addr = 8'hFF; data = 8'hFF; end
      if (ps && sioc && pd != siod_out) begin
        if (!siod_out) begin sf++; sf_cyc = cyc; end
        else begin sr++; sr_cyc = cyc; end
      end
      if (!ps && sioc) begin
        if (nrise < 27) begin
          if (nrise % 9 != 8) rx = {rx[22:0], siod_out};
          if (siod_oe !== ((nrise % 9 == 8) ? 1'b0 : 1'b1)) oe_bad++;
        end
        nrise++;
      end
      if (nrise == 17 && !siod_oe) ack_mid = ack_err;
      siod_in = ack2 && !siod_oe && nrise >= 17 && nrise <= 18;
      if (!busy && !done) nbusy_low++;
      if (done) begin
        lat = cyc - 1;
        ack_done = ack_err;
        if (busy) bad++;
        if (b2b) begin start = 1'b1; addr = 8'h5A; data = 8'hA5; end
      end
      ps = sioc; pd = siod_out;
    end
  endtask
  task automatic check_txn(input logic [23:0] exp_bytes, input logic exp_ack);
    `CHK("latency", lat, 228)
    `CHK("bytes", rx, exp_bytes)
    `CHK("sioc_rises", nrise, 28)
    `CHK("oe_pattern", oe_bad, 0)
    `CHK("start_cond_count", sf, 1)
    `CHK("stop_cond_count", sr, 1)
    `CHK("start_cond_time", sf_cyc, 3)
    `CHK("stop_cond_time", sr_cyc, 225)
    `CHK("busy_gap", nbusy_low, 0)
    `CHK("done_with_busy", bad, 0)
    `CHK("ack_c1", ack_c1, 1'b0)
    `CHK("ack_at_done", ack_done, exp_ack)
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; addr = 8'h00; data = 8'h00; siod_in = 1'b0;
    repeat (3) @(negedge clk);
    `CHK("rst_sioc", sioc, 1'b1)
    `CHK("rst_siod", siod_out, 1'b1)
    `CHK("rst_oe", siod_oe, 1'b1)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_ack", ack_err, 1'b0)
    rst = 1'b0;
    @(negedge clk);
    // single write
    addr = 8'h12; data = 8'h80; start = 1'b1;
    watch(0, 1'b0, 1'b0);
    check_txn({8'h42, 8'h12, 8'h80}, 1'b0);
    @(negedge clk);
    `CHK("done_one_cycle", done, 1'b0)
    `CHK("idle_busy", busy, 1'b0)
    // collision: second start at cycle 50 with different operands
    repeat (3) @(negedge clk);
    addr = 8'h12; data = 8'h80; start = 1'b1;
    watch(50, 1'b0, 1'b0);
    check_txn({8'h42, 8'h12, 8'h80}, 1'b0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    `CHK("collision_extra_done", ndone, 0)
    // back-to-back: start raised during the done cycle
    addr = 8'hC3; data = 8'h3C; start = 1'b1;
    watch(0, 1'b1, 1'b0);
    check_txn({8'h42, 8'hC3, 8'h3C}, 1'b0);
    watch(0, 1'b0, 1'b0);
    check_txn({8'h42, 8'h5A, 8'hA5}, 1'b0);
    // reset mid-transaction
    repeat (3) @(negedge clk);
    addr = 8'h12; data = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    `CHK("pre_rst_busy", busy, 1'b1)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    `CHK("mid_rst_sioc", sioc, 1'b1)
    `CHK("mid_rst_siod", siod_out, 1'b1)
    `CHK("mid_rst_oe", siod_oe, 1'b1)
    `CHK("mid_rst_busy", busy, 1'b0)
    `CHK("mid_rst_done", done, 1'b0)
    ndone = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    `CHK("post_rst_quiet", ndone, 0)
`ifdef SCCB_ACK_CHECK_EN
    // NACK in the second ACK slot only
    addr = 8'h12; data = 8'h80; start = 1'b1;
    watch(0, 1'b0, 1'b1);
    check_txn({8'h42, 8'h12, 8'h80}, 1'b1);
    `CHK("ack_before_slot2", ack_mid, 1'b0)
    @(negedge clk);
    `CHK("ack_sticky", ack_err, 1'b1)
    addr = 8'h12; data = 8'h80; start = 1'b1;
    watch(0, 1'b0, 1'b0);
    check_txn({8'h42, 8'h12, 8'h80}, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_write.md
# sccb_write

SCCB (OV7670-compatible, I2C-like) 3-phase write master. Sits directly downstream of the keypad configuration front end. It consumes the confirmed register address/data pair and the one-cycle `sccb_start` pulse, and serialises DEV_ID, sub-address and data onto SIO_C/SIO_D. It reports completion and, optionally, slave NACKs.

## Interface
- `CLK_FREQ`, 25000000, system clock frequency in Hz
- `SCCB_FREQ`, 100000, SIO_C frequency in Hz
- `DEV_ID`, 8'h42, camera write ID, sent in phase 1
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- `start`  in  1  request pulse (from `sccb_start`); accepted only in IDLE
- `addr`  in  8  register sub-address (from `conf_addr`)
- `data`  in  8  register value (from `conf_data`)
- `siod_in`  in  1  SIO_D pin readback; used only with the ACK-check configuration
- `sioc`  out  1  SIO_C
- `siod_out`  out  1  SIO_D drive value
- `siod_oe`  out  1  SIO_D output enable (1 = drive); the tristate buffer lives at top level
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle pulse at end of transaction
- `ack_err`  out  1  sticky NACK flag

## Operation
- Quarter tick: 16-bit counter, QTR = CLK_FREQ/(4*SCCB_FREQ) using integer floor, clamped to a minimum of 1. This gives 62 at the default parameters. All bus changes happen on quarter boundaries.
- Idle and reset values: `sioc`=1, `siod_out`=1, `siod_oe`=1, `busy`=0, `done`=0, `ack_err`=0.
- States: IDLE -> START -> BIT -> STOP -> IDLE.
- IDLE:
  - `start`=1 latches `addr`/`data` into a shift register along with `DEV_ID`.
  - Clears `ack_err` and the byte/bit counters.
  - Goes to START.
- START (2 quarters):
  - q0: `sioc`=1, `siod`=1.
  - q1: `sioc`=1, `siod`=0. This is the start condition.
  - Then BIT.
- BIT: 3 bytes (DEV_ID, addr, data). Each byte is 8 data bits MSB first plus a 9th "don't-care" bit.
  - Each bit is 4 quarters: q0/q1 `sioc`=0, q2/q3 `sioc`=1.
  - `siod_out` updates only at the start of q0.
  - During the 9th bit, `siod_oe`=0 for all 4 quarters. `siod_oe`=1 again from q0 of the next bit or STOP.
  - After byte 3, bit 9, go to STOP.
- STOP (4 quarters), `siod_oe`=1:
  - q0: `sioc`=0, `siod`=0.
  - q1: `sioc`=1, `siod`=0.
  - q2: `sioc`=1, `siod`=1. This is the stop condition.
  - q3: hold (bus free time).
- Return to IDLE, pulsing `done`.
- `start` while `busy`: ignored. There is no queueing, and latched operands are unaffected.
- `addr`/`data` changing mid-transaction: no effect.
- Reset mid-transaction: next cycle all outputs take their idle values. No stop condition is generated, the counters clear, and `done` is not pulsed.

## Timing
- `start` sampled high at edge N: `busy`=1 from N+1, and `sioc`/`siod` begin START q0 at N+1.
- Transaction length is 2 + 27*4 + 4 = 114 quarters, i.e. 114*QTR cycles. This is 7068 cycles at the defaults.
- `done`=1 and `busy`=0 in the same cycle, N+1+114*QTR. `done` lasts exactly 1 cycle.
- The FSM is in IDLE during the `done` cycle, so a `start` in that cycle is accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SCCB_ACK_CHECK_EN` defined:
  - `siod_in` is sampled on the first clock of q2 of each 9th bit.
  - If it reads 1, `ack_err` is set. It stays set until the next accepted `start` or reset.
  - The transaction always completes all 3 phases regardless.
- Undefined: `siod_in` is ignored, `ack_err` is constant 0, and the 9th bit is a pure don't-care.

## Test plan
- Defaults overridden: CLK_FREQ=800, SCCB_FREQ=100, so QTR=2.
- Single write: `start` pulse with addr=8'h12, data=8'h80 -> the decoded SIO_D bits at `sioc` rising edges are 0x42, 0x12, 0x80, each followed by `siod_oe`=0. `done` arrives exactly 228 cycles after N+1.
- Start/stop conditions: check that `siod` falls while `sioc`=1 at START q1, rises while `sioc`=1 at STOP q2, and never changes while `sioc`=1 elsewhere.
- Busy collision: second `start` (addr=8'hFF) at cycle N+50 -> ignored, the transaction still sends 0x12/0x80, exactly one `done`.
- Back-to-back: `start` asserted in the `done` cycle -> a new transaction begins the next cycle, and `busy` is low only during the `done` cycle.
- Reset mid-operation: `rst` at N+100 -> next cycle `sioc`=1, `siod_out`=1, `siod_oe`=1, `busy`=0; no `done` is pulsed.
- With `SCCB_ACK_CHECK_EN`: `siod_in`=1 during the 2nd ACK slot only -> `ack_err`=1 from that sample through `done`, and it clears on the next `start`. With all ACKs at 0, `ack_err` stays 0.
